prog_mem_arbiter: RTL and testbench
===================================

PROG_MEM_ARBITER -- requirements
Module: prog_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of fetcher requesters sharing one program memory read port (2..8).
REQ-002 Parameter PROGRAM_MEM_ADDR_WIDTH, default 6: program memory word address width.
REQ-003 Parameter INSTRUCTION_WIDTH, default 32: instruction word width.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester read request, level, bit i = requester i.
REQ-007 req_addr  input  NUM_REQ*PROGRAM_MEM_ADDR_WIDTH  flattened addresses, requester i at bits [i*W +: W].
REQ-008 req_ack  output  NUM_REQ  one-hot, single-cycle completion pulse to the granted requester.
REQ-009 req_data  output  INSTRUCTION_WIDTH  instruction broadcast to all requesters, valid while req_ack is nonzero.
REQ-010 mem_read_valid  output  1  read request to program memory.
REQ-011 mem_read_addr  output  PROGRAM_MEM_ADDR_WIDTH  address to program memory.
REQ-012 mem_read_ack  input  1  program memory completion, qualifies mem_read_data.
REQ-013 mem_read_data  input  INSTRUCTION_WIDTH  instruction from program memory.
REQ-014 grant_id  output  clog2(NUM_REQ)  index of requester currently or last granted.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 timeout_err  output  1  sticky memory-timeout flag (see Configuration).

Function
REQ-017 States IDLE, ISSUE, RESPOND; all outputs registered.
REQ-018 IDLE: if any req_valid bit set, grant the first set bit at or after rr_ptr (wrapping modulo NUM_REQ), latch its address and index, drive mem_read_valid=1 and mem_read_addr, go to ISSUE; else remain IDLE.
REQ-019 Latency: req_valid seen in IDLE at edge N gives mem_read_valid=1 after edge N.
REQ-020 ISSUE: hold mem_read_valid and mem_read_addr stable until mem_read_ack; on ack, capture mem_read_data into req_data, drive req_ack[grant_id]=1, clear mem_read_valid and mem_read_addr to 0, go to RESPOND.
REQ-021 RESPOND: lasts exactly one cycle; next edge clears req_ack to 0, sets rr_ptr=(grant_id+1) mod NUM_REQ, returns to IDLE.
REQ-022 Minimum transaction spacing: 3 cycles per grant with a zero-wait memory (IDLE, ISSUE, RESPOND).
REQ-023 Latched address is used for the whole transaction; changes on req_addr after the grant are ignored.
REQ-024 Granted requester dropping req_valid mid-transaction does not abort; the transaction completes and the req_ack pulse is still issued.
REQ-025 Requester holding req_valid high after its ack is re-eligible, at lowest priority due to the rr_ptr advance.
REQ-026 mem_read_ack outside ISSUE is ignored.
REQ-027 req_data holds its last captured value until the next capture.

Reset
REQ-028 On rst: state=IDLE, rr_ptr=0, grant_id=0, req_ack=0, req_data=0, mem_read_valid=0, mem_read_addr=0, busy=0, timeout_err=0, timeout counter=0.
REQ-029 rst mid-transaction abandons it without req_ack; a later mem_read_ack for it is ignored.

Configuration
REQ-030 Macro PROG_MEM_ARB_TIMEOUT_EN defined: 8-bit counter clears on entry to ISSUE and increments each ISSUE cycle without ack; on reaching 255 go to IDLE with mem_read_valid=0, no req_ack, timeout_err set, rr_ptr advanced past grant_id.
REQ-031 timeout_err clears only on rst.
REQ-032 Macro not defined: no counter, ISSUE waits indefinitely, timeout_err tied to 0.

Verification
REQ-033 Single request: req_valid=4'b0010, addr1=6'h05, memory acks 2 cycles after valid with 32'hDEADBEEF -> mem_read_addr=5, then req_ack=4'b0010 for one cycle with req_data=DEADBEEF.
REQ-034 Round robin: req_valid=4'b1111 held -> grant order 0,1,2,3,0; each req_ack one-hot, one cycle.
REQ-035 Address stability: change addr of granted requester during ISSUE -> mem_read_addr unchanged until ack.
REQ-036 Reset mid-ISSUE: assert rst, then ack arrives -> no req_ack, all outputs 0, next grant is requester 0.
REQ-037 Wrap: rr_ptr=3 after grant to 2, req_valid=4'b0011 -> requester 0 granted.
REQ-038 With PROG_MEM_ARB_TIMEOUT_EN: memory never acks -> after 255 ISSUE cycles timeout_err=1, state IDLE, next pending requester granted.

Source files
------------

// File: rtl/prog_mem_arbiter_if.sv
// Program memory arbiter bus: fetcher requests/acks plus the
// shared program memory read port and status flags.
interface prog_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
    parameter int INSTRUCTION_WIDTH = 32
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int AW = PROGRAM_MEM_ADDR_WIDTH;
    localparam int IW = INSTRUCTION_WIDTH;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_ack;
    logic [IW-1:0]         req_data;
    logic                  mem_read_valid;
    logic [AW-1:0]         mem_read_addr;
    logic                  mem_read_ack;
    logic [IW-1:0]         mem_read_data;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        output req_valid, req_addr,
        output mem_read_ack, mem_read_data,
        input  req_ack, req_data,
        input  mem_read_valid, mem_read_addr,
        input  grant_id, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_addr,
        input  mem_read_ack, mem_read_data,
        output req_ack, req_data,
        output mem_read_valid, mem_read_addr,
        output grant_id, busy, timeout_err
    );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Round-robin arbiter sharing one program memory read port among fetchers.
// Define PROG_MEM_ARB_TIMEOUT_EN to abort reads after 255 stalled cycles.
module prog_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    prog_mem_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int AW = PROGRAM_MEM_ADDR_WIDTH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    logic [1:0]    state;
    logic [GW-1:0] rr_ptr;
    logic          found;
    logic [GW-1:0] pick;
    logic [GW:0]   sum;
    logic [GW-1:0] next_ptr;

`ifdef PROG_MEM_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_err;
    assign bus.timeout_err = tmo_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (GW+1)'(k);
            if (sum >= (GW+1)'(NUM_REQ))
                sum = sum - (GW+1)'(NUM_REQ);
            if (!found && bus.req_valid[sum[GW-1:0]]) begin
                found = 1'b1;
                pick  = sum[GW-1:0];
            end
        end
    end

    assign next_ptr = (bus.grant_id == GW'(NUM_REQ-1)) ?
                      '0 : bus.grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            bus.grant_id       <= '0;
            bus.req_ack        <= '0;
            bus.req_data       <= '0;
            bus.mem_read_valid <= 1'b0;
            bus.mem_read_addr  <= '0;
            bus.busy           <= 1'b0;
`ifdef PROG_MEM_ARB_TIMEOUT_EN
            tmo_cnt            <= '0;
            tmo_err            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state              <= ISSUE;
                        bus.grant_id       <= pick;
                        bus.mem_read_valid <= 1'b1;
                        bus.mem_read_addr  <= bus.req_addr[pick*AW +: AW];
                        bus.busy           <= 1'b1;
`ifdef PROG_MEM_ARB_TIMEOUT_EN
                        tmo_cnt            <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (bus.mem_read_ack) begin
                        state              <= RESPOND;
                        bus.req_data       <= bus.mem_read_data;
                        bus.req_ack        <= NUM_REQ'(1) << bus.grant_id;
                        bus.mem_read_valid <= 1'b0;
                        bus.mem_read_addr  <= '0;
                    end
`ifdef PROG_MEM_ARB_TIMEOUT_EN
                    // 255th stalled cycle abandons the read.
                    else if (tmo_cnt == 8'd254) begin
                        state              <= IDLE;
                        rr_ptr             <= next_ptr;
                        bus.mem_read_valid <= 1'b0;
                        bus.mem_read_addr  <= '0;
                        bus.busy           <= 1'b0;
                        tmo_err            <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                RESPOND: begin
                    state       <= IDLE;
                    rr_ptr      <= next_ptr;
                    bus.req_ack <= '0;
                    bus.busy    <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Randomized bench for prog_mem_arbiter against a transaction-level
// round-robin model; acts as the program memory itself.
module tb_prog_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int IW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   model_ptr = 0;

    always #5 clk = ~clk;

    prog_mem_arbiter_if #(
        .NUM_REQ(N),
        .PROGRAM_MEM_ADDR_WIDTH(AW),
        .INSTRUCTION_WIDTH(IW)
    ) bus ();

    prog_mem_arbiter #(
        .NUM_REQ(N),
        .PROGRAM_MEM_ADDR_WIDTH(AW),
        .INSTRUCTION_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Model: first requester at or after ptr, wrapping.
    function automatic int model_pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [AW-1:0] addr_of(int i);
        logic [N*AW-1:0] a;
        a = bus.req_addr;
        return a[i*AW +: AW];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.mem_read_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Plays memory for one transaction and reports what it saw.
    task automatic serve(
        input  int lat,
        input  logic [IW-1:0] data,
        input  bit scramble,
        input  bit drop,
        output int wait_cyc,
        output int gid,
        output logic [AW-1:0] addr,
        output bit moved,
        output logic [N-1:0] ack_vec,
        output logic [IW-1:0] dat,
        output logic [N-1:0] ack_after,
        output bit to
    );
        wait_cyc = 0;
        moved = 1'b0;
        to = 1'b0;
        gid = -1;
        addr = '0;
        ack_vec = '0;
        dat = '0;
        ack_after = '0;
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (!bus.mem_read_valid && wait_cyc < 50);
        if (!bus.mem_read_valid) begin
            to = 1'b1;
            return;
        end
        gid = int'(bus.grant_id);
        addr = bus.mem_read_addr;
        if (drop) bus.req_valid[gid] = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (scramble) bus.req_addr = (N*AW)'($urandom);
            @(negedge clk);
            if (bus.mem_read_addr !== addr || bus.mem_read_valid !== 1'b1)
                moved = 1'b1;
        end
        bus.mem_read_ack = 1'b1;
        bus.mem_read_data = data;
        @(negedge clk);
        ack_vec = bus.req_ack;
        dat = bus.req_data;
        bus.mem_read_ack = 1'b0;
        bus.mem_read_data = $urandom;
        @(negedge clk);
        ack_after = bus.req_ack;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.req_ack !== '0) begin
            failures++;
            $display("FAIL rst_req_ack got=%h exp=0", bus.req_ack);
        end
        checks++;
        if (bus.req_data !== '0) begin
            failures++;
            $display("FAIL rst_req_data got=%h exp=0", bus.req_data);
        end
        checks++;
        if (bus.mem_read_valid !== 1'b0 || bus.mem_read_addr !== '0) begin
            failures++;
            $display("FAIL rst_mem got=%b/%h exp=0/0",
                     bus.mem_read_valid, bus.mem_read_addr);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== '0) begin
            failures++;
            $display("FAIL rst_busy_gid got=%b/%0d exp=0/0",
                     bus.busy, bus.grant_id);
        end
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_timeout got=%b exp=0", bus.timeout_err);
        end
    endtask

    task automatic test_single();
        int w, g;
        logic [AW-1:0] a;
        bit mv, to;
        logic [N-1:0] av, aa;
        logic [IW-1:0] d;
        do_reset();
        bus.req_addr = '0;
        bus.req_addr[1*AW +: AW] = 6'h05;
        bus.req_valid = 4'b0010;
        serve(2, 32'hDEADBEEF, 0, 0, w, g, a, mv, av, d, aa, to);
        bus.req_valid = '0;
        checks++;
        if (to || w !== 1) begin
            failures++;
            $display("FAIL single_latency got=%0d to=%b exp=1", w, to);
        end
        checks++;
        if (a !== 6'h05 || g !== 1) begin
            failures++;
            $display("FAIL single_addr got=%h/%0d exp=05/1", a, g);
        end
        checks++;
        if (av !== 4'b0010 || d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_ack got=%b/%h exp=0010/deadbeef", av, d);
        end
        checks++;
        if (aa !== '0 || bus.req_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_pulse got=%b/%h exp=0000/deadbeef",
                     aa, bus.req_data);
        end
        model_ptr = 2;
    endtask

    task automatic test_ignore_ack();
        logic [IW-1:0] held;
        repeat (2) @(negedge clk);
        held = bus.req_data;
        bus.mem_read_ack = 1'b1;
        bus.mem_read_data = 32'h12345678;
        repeat (2) @(negedge clk);
        bus.mem_read_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ack !== '0 || bus.busy !== 1'b0 ||
            bus.mem_read_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack got=%b/%b/%b exp=0/0/0",
                     bus.req_ack, bus.busy, bus.mem_read_valid);
        end
        checks++;
        if (bus.req_data !== held) begin
            failures++;
            $display("FAIL data_hold got=%h exp=%h", bus.req_data, held);
        end
    endtask

    task automatic test_round_robin();
        int w, g, exp_g;
        int order[5] = '{0, 1, 2, 3, 0};
        logic [AW-1:0] a;
        bit mv, to;
        logic [N-1:0] av, aa;
        logic [IW-1:0] d, dat;
        do_reset();
        bus.req_addr = (N*AW)'({$urandom, $urandom});
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            dat = $urandom;
            exp_g = model_pick(bus.req_valid, model_ptr);
            serve(0, dat, 0, 0, w, g, a, mv, av, d, aa, to);
            checks++;
            if (to || g !== exp_g || g !== order[t]) begin
                failures++;
                $display("FAIL rr_grant t=%0d got=%0d exp=%0d", t, g, exp_g);
            end
            checks++;
            if (av !== 4'(1 << exp_g) || aa !== '0 || d !== dat) begin
                failures++;
                $display("FAIL rr_ack t=%0d got=%b/%b/%h exp=%b/0/%h",
                         t, av, aa, d, 4'(1 << exp_g), dat);
            end
            if (t > 0) begin
                checks++;
                if (w !== 1) begin
                    failures++;
                    $display("FAIL rr_spacing t=%0d got=%0d exp=1", t, w);
                end
            end
            model_ptr = (exp_g + 1) % N;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_addr_stability();
        int w, g, exp_g;
        logic [AW-1:0] a, exp_a;
        bit mv, to;
        logic [N-1:0] av, aa;
        logic [IW-1:0] d;
        @(negedge clk);
        bus.req_addr = (N*AW)'({$urandom, $urandom});
        bus.req_valid = 4'b0001;
        exp_g = model_pick(bus.req_valid, model_ptr);
        exp_a = addr_of(exp_g);
        serve(5, 32'hA5A5_0F0F, 1, 1, w, g, a, mv, av, d, aa, to);
        checks++;
        if (to || g !== exp_g || a !== exp_a) begin
            failures++;
            $display("FAIL stab_grant got=%0d/%h exp=%0d/%h", g, a, exp_g, exp_a);
        end
        checks++;
        if (mv !== 1'b0) begin
            failures++;
            $display("FAIL stab_addr got=moved exp=stable");
        end
        checks++;
        if (av !== 4'(1 << exp_g) || d !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL drop_ack got=%b/%h exp=%b/a5a50f0f",
                     av, d, 4'(1 << exp_g));
        end
        model_ptr = (exp_g + 1) % N;
        bus.req_valid = '0;
    endtask

    task automatic test_wrap();
        int w, g;
        logic [AW-1:0] a;
        bit mv, to;
        logic [N-1:0] av, aa;
        logic [IW-1:0] d;
        do_reset();
        bus.req_valid = 4'b0100;
        serve(1, 32'h1, 0, 0, w, g, a, mv, av, d, aa, to);
        bus.req_valid = 4'b0011;
        serve(0, 32'h2, 0, 0, w, g, a, mv, av, d, aa, to);
        checks++;
        if (to || g !== 0 || av !== 4'b0001) begin
            failures++;
            $display("FAIL wrap got=%0d/%b exp=0/0001", g, av);
        end
        bus.req_valid = '0;
        model_ptr = 1;
    endtask

    task automatic test_reset_mid();
        int w, g;
        logic [AW-1:0] a;
        bit mv, to;
        logic [N-1:0] av, aa;
        logic [IW-1:0] d;
        @(negedge clk);
        bus.req_valid = 4'b0100;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.mem_read_valid && w < 20);
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_read_ack = 1'b1;
        bus.mem_read_data = 32'hBAD0BAD0;
        @(negedge clk);
        bus.mem_read_ack = 1'b0;
        checks++;
        if (bus.req_ack !== '0 || bus.req_data !== '0 ||
            bus.mem_read_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.grant_id !== '0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%h/%b/%b/%0d exp=0/0/0/0/0",
                     bus.req_ack, bus.req_data, bus.mem_read_valid,
                     bus.busy, bus.grant_id);
        end
        @(negedge clk);
        bus.req_valid = 4'b1111;
        serve(0, 32'h3, 0, 0, w, g, a, mv, av, d, aa, to);
        checks++;
        if (to || g !== 0) begin
            failures++;
            $display("FAIL rst_mid_next got=%0d exp=0", g);
        end
        bus.req_valid = '0;
        model_ptr = 1;
    endtask

    task automatic test_random();
        int w, g, exp_g, lat;
        logic [AW-1:0] a, exp_a;
        bit mv, to;
        logic [N-1:0] av, aa;
        logic [IW-1:0] d, dat;
        for (int t = 0; t < 40; t++) begin
            bus.req_valid = 4'($urandom_range(1, 15));
            bus.req_addr = (N*AW)'({$urandom, $urandom});
            dat = $urandom;
            lat = $urandom_range(0, 5);
            exp_g = model_pick(bus.req_valid, model_ptr);
            exp_a = addr_of(exp_g);
            serve(lat, dat, 0, 0, w, g, a, mv, av, d, aa, to);
            checks++;
            if (to || g !== exp_g || a !== exp_a || w !== 1) begin
                failures++;
                $display("FAIL rnd_grant t=%0d got=%0d/%h/%0d exp=%0d/%h/1",
                         t, g, a, w, exp_g, exp_a);
            end
            checks++;
            if (av !== 4'(1 << exp_g) || d !== dat || aa !== '0) begin
                failures++;
                $display("FAIL rnd_ack t=%0d got=%b/%h/%b exp=%b/%h/0",
                         t, av, d, aa, 4'(1 << exp_g), dat);
            end
            model_ptr = (exp_g + 1) % N;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_timeout();
        int w, g, exp_g, n;
        logic [AW-1:0] a;
        bit mv, to;
        logic [N-1:0] av, aa;
        logic [IW-1:0] d;
        @(negedge clk);
        bus.req_valid = 4'b0011;
        exp_g = model_pick(bus.req_valid, model_ptr);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.mem_read_valid && w < 20);
        n = 0;
`ifdef PROG_MEM_ARB_TIMEOUT_EN
        while (bus.mem_read_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 255 || bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout got=%0d/%b/%b exp=255/1/0",
                     n, bus.timeout_err, bus.busy);
        end
        model_ptr = (exp_g + 1) % N;
        exp_g = model_pick(bus.req_valid, model_ptr);
        serve(0, 32'h4, 0, 0, w, g, a, mv, av, d, aa, to);
        checks++;
        if (to || g !== exp_g || bus.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_next got=%0d/%b exp=%0d/1",
                     g, bus.timeout_err, exp_g);
        end
`else
        while (bus.mem_read_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 300 || bus.timeout_err !== 1'b0 || g === -2) begin
            failures++;
            $display("FAIL no_timeout got=%0d/%b exp=300/0",
                     n, bus.timeout_err);
        end
        serve(0, 32'h4, 0, 0, w, g, a, mv, av, d, aa, to);
        checks++;
        if (to || g !== exp_g || av !== 4'(1 << exp_g)) begin
            failures++;
            $display("FAIL stall_done got=%0d/%b exp=%0d", g, av, exp_g);
        end
`endif
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.mem_read_ack = 1'b0;
        bus.mem_read_data = '0;
        test_reset();
        test_single();
        test_ignore_ack();
        test_round_robin();
        test_addr_stability();
        test_wrap();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
